upsample_window_gen: RTL
========================

Name: upsample_window_gen

Overview:
- Streaming window former that sits directly upstream of the 2x2 bilinear upsample datapath.
- Accepts a feature-map tile one pixel per handshake, in raster order (row-major).
- Buffers one previous row and the previous pixel.
- Emits every overlapping 2x2 window (a=top-left, b=top-right, c=bottom-left, d=bottom-right), tagged with a 4-bit write_mode position code that tells the downstream stage which edge/corner outputs to produce.

Parameters:
- length, 16, pixel word width in bits.
- img_w, 8, tile width in pixels (min 2).
- img_h, 8, tile height in pixels (min 2).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  length  pixel, raster order.
- out_valid  output  1  window outputs valid.
- out_ready  input  1  downstream accepts window.
- a  output  length  window top-left, pixel (r-1, c-1).
- b  output  length  window top-right, pixel (r-1, c).
- c  output  length  window bottom-left, pixel (r, c-1).
- d  output  length  window bottom-right, pixel (r, c).
- write_mode  output  4  window position code.
- out_last  output  1  high with the final window of a tile.

Behaviour:
- One clock (clk); synchronous active-high reset (rst).
- Reset:
  - out_valid=0, out_last=0; a, b, c, d = 0; write_mode=4'b0000.
  - Column/row counters = 0; held registers = 0.
  - Line-buffer RAM is not reset (contents are never read before being rewritten).
- Input acceptance: in_ready = !out_valid || out_ready (combinational). A pixel is accepted when in_valid && in_ready.
- Counters:
  - col 0..img_w-1, row 0..img_h-1, advanced only on accept.
  - col wraps to 0 and row increments at col=img_w-1.
  - At row=img_h-1, col=img_w-1, both wrap to 0 and the next accepted pixel starts a new tile with no idle cycle.
- Storage:
  - Line buffer of img_w entries holds the previous row; entry [col] is overwritten with the accepted pixel.
  - Registers hold the previous pixel of the current row and the previous row's pixel at col-1.
- Window emission:
  - Accepting pixel (r, c) with r>=1 and c>=1 completes window (wr=r-1, wc=c-1).
  - On the next edge: out_valid=1; a, b, c, d, write_mode, out_last registered (latency 1 cycle).
  - Row 0 and column 0 pixels produce no window.
  - Per tile: (img_h-1)*(img_w-1) windows.
- out_valid / out_ready:
  - out_valid stays high with outputs stable until out_valid && out_ready.
  - Accept and emit in the same cycle is allowed (full throughput, 1 window/cycle).
  - If the handshake completes and no new window is produced, out_valid falls to 0.
- write_mode (LW = img_w-2, LH = img_h-2):
  - wr=0: wc=0 -> 4'b1000; wc=LW -> 4'b0110; otherwise 4'b0111.
  - wr>0, wc=0: wr=LH -> 4'b0010; otherwise 4'b0101.
  - wr>0, wc>0: wr=LH and wc=LW -> 4'b0000; otherwise 4'b0001 (interior).
  - Evaluation is top-to-bottom; the first match wins. This matters for img_w=2 or img_h=2.
- out_last = 1 only for window wr=LH, wc=LW.
- rst mid-tile: everything returns to the reset state on that edge, any pending window is discarded, and the next accepted pixel is treated as pixel (0,0).
- in_valid low: counters and storage hold; the pending output remains.

Test Plan:
1. img_w=4, img_h=3, pixels 1..12, out_ready=1 -> exactly 6 windows, each 1 cycle after accepting its completing pixel:
   - (1,2,5,6) 1000
   - (2,3,6,7) 0111
   - (3,4,7,8) 0110
   - (5,6,9,10) 0010
   - (6,7,10,11) 0001
   - (7,8,11,12) 0000 with out_last=1
2. img_w=4, img_h=4, pixels 1..16 -> window (5,6,9,10) has mode 0101; window (9,10,13,14) has mode 0010; last window (11,12,15,16) has mode 0000 with out_last=1.
3. Same stream as test 1, with out_ready held low for 5 cycles after the first window -> in_ready=0 throughout; window (1,2,5,6) holds stable; no pixel is lost; full window sequence is identical to test 1.
4. Two img_w=4, img_h=3 tiles back-to-back (1..12, then 101..112) -> second tile's first window is (101,102,105,106) 1000; no window mixes data from the two tiles.
5. Assert rst after pixel 7 of a tile, then stream 1..12 -> out_valid=0 on the cycle after reset; subsequent output matches test 1 exactly.
6. img_w=2, img_h=2, pixels 1..4 -> single window (1,2,3,4) with mode 1000 and out_last=1.

Source files
------------

// File: rtl/upsample_window_gen.sv
// Streaming 2x2 window former: raster-order pixels in, overlapping windows out,
// each tagged with an edge/corner position code for the bilinear upsampler.
module upsample_window_gen #(
  parameter int length = 16,
  parameter int img_w  = 8,
  parameter int img_h  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [length-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [length-1:0] a,
  output logic [length-1:0] b,
  output logic [length-1:0] c,
  output logic [length-1:0] d,
  output logic [3:0]        write_mode,
  output logic              out_last
);

  localparam int cw = (img_w > 1) ? $clog2(img_w) : 1;
  localparam int rw = (img_h > 1) ? $clog2(img_h) : 1;
  localparam logic [cw-1:0] last_col = cw'(img_w - 1);
  localparam logic [rw-1:0] last_row = rw'(img_h - 1);

  logic [cw-1:0]     col_reg, col_next;
  logic [rw-1:0]     row_reg, row_next;
  logic [length-1:0] line_mem [img_w];
  logic [length-1:0] top_rd_reg;
  logic [length-1:0] top_prev_reg;
  logic [length-1:0] pix_prev_reg;
  logic [cw-1:0]     rd_addr;
  logic              accept;
  logic              win_valid;
  logic [3:0]        mode_next;
  logic              last_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (accept) begin
      if (col_reg == last_col) begin
        col_next = '0;
        row_next = (row_reg == last_row) ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  // Window (row-1, col-1) completes when pixel (row, col) arrives; the
  // position code is decoded from the completing pixel's coordinates.
  always_comb begin
    win_valid = accept && (row_reg != '0) && (col_reg != '0);
    last_next = (row_reg == last_row) && (col_reg == last_col);
    mode_next = 4'b0001;
    if (row_reg == rw'(1)) begin
      if (col_reg == cw'(1))          mode_next = 4'b1000;
      else if (col_reg == last_col)   mode_next = 4'b0110;
      else                            mode_next = 4'b0111;
    end else if (col_reg == cw'(1)) begin
      mode_next = (row_reg == last_row) ? 4'b0010 : 4'b0101;
    end else if (last_next) begin
      mode_next = 4'b0000;
    end
  end

  // The read port is pre-addressed with the column the next pixel will land
  // on, so top_rd_reg always holds the previous row's pixel above it. The
  // write (col) and read (col_next) addresses differ whenever a write occurs.
  assign rd_addr = rst ? '0 : col_next;

  always_ff @(posedge clk) begin
    if (accept && !rst) line_mem[col_reg] <= in_data;
    top_rd_reg <= line_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg      <= '0;
      row_reg      <= '0;
      top_prev_reg <= '0;
      pix_prev_reg <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      a            <= '0;
      b            <= '0;
      c            <= '0;
      d            <= '0;
      write_mode   <= 4'b0000;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
      if (accept) begin
        pix_prev_reg <= in_data;
        top_prev_reg <= top_rd_reg;
      end
      if (win_valid) begin
        out_valid  <= 1'b1;
        a          <= top_prev_reg;
        b          <= top_rd_reg;
        c          <= pix_prev_reg;
        d          <= in_data;
        write_mode <= mode_next;
        out_last   <= last_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
